// File: rtl/adc_frame_capt.sv
// rtl/adc_frame_capt.sv - serial ADC frame capture with lead/gap skipping and atomic frame output
module adc_frame_capt #(
    parameter int DATA_W = 12,
    parameter int N_CH   = 2,
    parameter int LEAD   = 9,
    parameter int GAP    = 4
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     START,
    input  logic                     BIT_EN,
    input  logic                     ADC_DOUT,
    input  logic                     ABORT,
    input  logic                     CLR_OVR,
    output logic [N_CH*DATA_W-1:0]   DATA_OUT,
    output logic                     FRAME_VALID,
    output logic                     BUSY,
    output logic                     OVERRUN
);

    localparam int MAX_SKIP = (LEAD > GAP) ? LEAD : GAP;
    localparam int MAX_CNT  = (MAX_SKIP > DATA_W) ? MAX_SKIP : DATA_W;
    localparam int BW       = $clog2(MAX_CNT + 1);
    localparam int CW       = $clog2(N_CH + 1);

    localparam logic [BW-1:0] LEAD_LAST = BW'((LEAD > 0) ? LEAD - 1 : 0);
    localparam logic [BW-1:0] GAP_LAST  = BW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [BW-1:0] DW_LAST   = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_SKIP,
        SHIFT,
        GAP_SKIP,
        DONE
    } state_t;

    state_t                   state_q;
    logic [BW-1:0]            bit_cnt_q;
    logic [CW-1:0]            ch_q;
    // Only DATA_W-1 bits are held; the final LSB goes straight into the frame buffer.
    logic [DATA_W-2:0]        shadow_q;
    logic [N_CH*DATA_W-1:0]   frame_q;
    logic [N_CH*DATA_W-1:0]   data_out_q;
    logic                     frame_valid_q;
    logic                     busy_q;
    logic                     overrun_q;

    logic [DATA_W-1:0]        word_d;
    logic [N_CH*DATA_W-1:0]   frame_d;

    always_comb begin
        word_d  = {shadow_q, ADC_DOUT};
        frame_d = frame_q;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q == CW'(k)) begin
                frame_d[k*DATA_W +: DATA_W] = word_d;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            ch_q          <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            data_out_q    <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;

            if (START && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (CLR_OVR) begin
                overrun_q <= 1'b0;
            end

            if (ABORT) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (START) begin
                            bit_cnt_q <= '0;
                            ch_q      <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= (LEAD == 0) ? SHIFT : LEAD_SKIP;
                        end
                    end
                    LEAD_SKIP: begin
                        if (BIT_EN) begin
                            if (bit_cnt_q == LEAD_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= SHIFT;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end
                    end
                    SHIFT: begin
                        if (BIT_EN) begin
                            shadow_q <= word_d[DATA_W-2:0];
                            if (bit_cnt_q == DW_LAST) begin
                                bit_cnt_q <= '0;
                                frame_q   <= frame_d;
                                if (ch_q == CH_LAST) begin
                                    data_out_q    <= frame_d;
                                    frame_valid_q <= 1'b1;
                                    state_q       <= DONE;
                                end else begin
                                    ch_q    <= ch_q + CW'(1);
                                    state_q <= (GAP == 0) ? SHIFT : GAP_SKIP;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end
                    end
                    GAP_SKIP: begin
                        if (BIT_EN) begin
                            if (bit_cnt_q == GAP_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= SHIFT;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BW'(1);
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DATA_OUT    = data_out_q;
    assign FRAME_VALID = frame_valid_q;
    assign BUSY        = busy_q;
    assign OVERRUN     = overrun_q;

endmodule

// File: doc/adc_frame_capt.md
ADC_FRAME_CAPT -- requirements
Module: adc_frame_capt

Interface
REQ-001 Parameter DATA_W, default 12, sets bits per channel sample.
REQ-002 Parameter N_CH, default 2, sets channels per frame (channel 0 = X, 1 = Y).
REQ-003 Parameter LEAD, default 9, sets bits skipped after START before channel 0 MSB.
REQ-004 Parameter GAP, default 4, sets bits skipped between the LSB of channel k and the MSB of channel k+1.
REQ-005 CLK  input  1  system clock, all logic on rising edge.
REQ-006 RST_n  input  1  asynchronous, active-low reset.
REQ-007 START  input  1  one-cycle pulse, begins a frame.
REQ-008 BIT_EN  input  1  one-cycle strobe per serial bit; ADC_DOUT is sampled only when high.
REQ-009 ADC_DOUT  input  1  serial ADC data, MSB first.
REQ-010 ABORT  input  1  synchronous frame cancel.
REQ-011 CLR_OVR  input  1  clears OVERRUN.
REQ-012 DATA_OUT  output  N_CH*DATA_W  last complete frame; channel k at bits [k*DATA_W +: DATA_W].
REQ-013 FRAME_VALID  output  1  one-cycle pulse when DATA_OUT is updated.
REQ-014 BUSY  output  1  high while a frame is in progress.
REQ-015 OVERRUN  output  1  sticky flag, START received while BUSY.

Function
REQ-016 States: IDLE, LEAD_SKIP, SHIFT, GAP_SKIP, DONE; the block SHALL implement exactly these.
REQ-017 IDLE: START=1 -> LEAD_SKIP (LEAD=0 -> SHIFT directly); bit counter and channel counter cleared.
REQ-018 LEAD_SKIP: counts BIT_EN strobes; after LEAD strobes -> SHIFT; ADC_DOUT ignored.
REQ-019 SHIFT: each BIT_EN shifts ADC_DOUT into a DATA_W shadow register, MSB first; after DATA_W strobes the shadow word is written to the channel's slot of an internal frame buffer.
REQ-020 SHIFT end: channel < N_CH-1 -> GAP_SKIP (GAP=0 -> SHIFT) with channel+1; channel = N_CH-1 -> DONE.
REQ-021 GAP_SKIP: after GAP strobes -> SHIFT; ADC_DOUT ignored.
REQ-022 DONE: lasts one cycle; frame buffer copied to DATA_OUT, FRAME_VALID=1, -> IDLE.
REQ-023 DATA_OUT SHALL change only in DONE; partial frames never visible (atomic update).
REQ-024 FRAME_VALID latency: exactly 1 cycle after the cycle sampling the last LSB.
REQ-025 BUSY=1 in LEAD_SKIP, SHIFT, GAP_SKIP, DONE; 0 in IDLE.
REQ-026 START while BUSY: ignored for sequencing, OVERRUN set to 1 next cycle.
REQ-027 CLR_OVR=1 clears OVERRUN; simultaneous CLR_OVR and overrun-START -> OVERRUN=1 (set wins).
REQ-028 ABORT=1 in any state -> IDLE next cycle, no FRAME_VALID, DATA_OUT keeps previous frame; ABORT has priority over BIT_EN and START in the same cycle.
REQ-029 START and ABORT in same cycle in IDLE -> remain IDLE.
REQ-030 BIT_EN in IDLE or DONE SHALL be ignored.
REQ-031 Bit counter width SHALL be ceil(log2(max(LEAD,GAP,DATA_W)+1)); channel counter ceil(log2(N_CH+1)); no wrap inside a phase.
REQ-032 Total strobes per frame SHALL be LEAD + N_CH*DATA_W + (N_CH-1)*GAP (defaults: 9+24+4 = 37).

Reset
REQ-033 RST_n=0 SHALL asynchronously force IDLE, DATA_OUT=0, FRAME_VALID=0, BUSY=0, OVERRUN=0, shadow, frame buffer and counters to 0.
REQ-034 Reset release mid-frame SHALL resume in IDLE; no frame completes without a new START.

Verification
REQ-035 Defaults, START, 37 strobes carrying X=12'hA5C, Y=12'h3F1 after 9 lead and 4 gap bits -> FRAME_VALID pulse, DATA_OUT=24'h3F1A5C, BUSY falls same cycle as DONE exit.
REQ-036 Second frame X=12'h001, Y=12'hFFF; check DATA_OUT holds 24'h3F1A5C until DONE, then 24'hFFF001 in one step.
REQ-037 ABORT after 20 strobes -> BUSY=0 next cycle, no FRAME_VALID, DATA_OUT unchanged; next full frame captures correctly.
REQ-038 START at strobe 15 of an active frame -> OVERRUN=1, frame completes normally; CLR_OVR -> OVERRUN=0; CLR_OVR with overrun START same cycle -> OVERRUN=1.
REQ-039 Parameters DATA_W=8, N_CH=4, LEAD=0, GAP=0: 32 strobes of 8'h11,8'h22,8'h33,8'h44 -> DATA_OUT=32'h44332211.
REQ-040 RST_n asserted mid-SHIFT asynchronously -> all outputs 0 immediately; BIT_EN after release without START -> no FRAME_VALID.
